// File: rtl/fios_pkg.sv
// Shared types and helpers for the word-serial FIOS Montgomery multiplier.
// FIOS_FINAL_SUB_EN adds the final conditional subtraction (SUB state).
package fios_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StSub,
        StDone
    } fios_state_e;

    // x + y*z + u*v + carry for W-bit words never exceeds 2W+2 bits.
    function automatic int unsigned fios_mac_width(input int unsigned w);
        return 2 * w + 2;
    endfunction

    // Cycles from the accept edge to the edge that raises valid_o.
    function automatic int unsigned fios_latency(input int unsigned w, input int unsigned s);
        int unsigned lat;
        lat = s * (s + 1) + 1;
`ifdef FIOS_FINAL_SUB_EN
        lat = lat + s + 1;
`endif
        return (w >= 4) ? lat : 0;
    endfunction

endpackage

// File: rtl/fios_mac.sv
// Combinational word MAC: x + y*z + u*v + carry, wide enough that no carry is lost.
module fios_mac
    import fios_pkg::*;
#(
    parameter int unsigned W = 17
) (
    input  logic [W-1:0]                  x_i,
    input  logic [W-1:0]                  y_i,
    input  logic [W-1:0]                  z_i,
    input  logic [W-1:0]                  u_i,
    input  logic [W-1:0]                  v_i,
    input  logic [W+1:0]                  c_i,
    output logic [fios_mac_width(W)-1:0]  s_o
);

    localparam int unsigned MW = fios_mac_width(W);

    assign s_o = MW'(x_i) + MW'(y_i) * MW'(z_i) + MW'(u_i) * MW'(v_i) + MW'(c_i);

endmodule

// File: rtl/fios_mm_wordserial.sv
// Word-serial FIOS Montgomery multiplier, one word MAC per cycle.
// Define FIOS_FINAL_SUB_EN to reduce the result below p with a serial final subtraction.
module fios_mm_wordserial
    import fios_pkg::*;
#(
    parameter int unsigned W = 17,
    parameter int unsigned S = 8
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    output logic             idle_o,
    input  logic [W*S-1:0]   a_i,
    input  logic [W*S-1:0]   b_i,
    input  logic [W*S-1:0]   p_i,
    input  logic [W-1:0]     p_prime_0_i,
    output logic [W*S:0]     res_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int unsigned N  = W * S;
    localparam int unsigned MW = fios_mac_width(W);
    localparam int unsigned CW = $clog2(S + 1);
    localparam logic [CW-1:0] JMax = CW'(S);
    localparam logic [CW-1:0] IMax = CW'(S - 1);

    fios_state_e      state_q;
    logic [CW-1:0]    i_q, j_q;
    logic [N-1:0]     a_q, b_q, p_q;
    logic [W-1:0]     pp_q;
    logic [N+W-1:0]   t_q;
    logic [W-1:0]     m_q;
    logic [W+1:0]     c_q;
    logic [N:0]       res_q;
    logic             valid_q;

    logic [CW-1:0]    ja;
    logic [W-1:0]     t_word, a_word, b_word, p_word;
    logic [W-1:0]     lo, m_now;
    logic [W-1:0]     mac_y, mac_u, mac_v;
    logic [W+1:0]     mac_c;
    logic [MW-1:0]    mac_s;

    always_comb begin
        // a and p have only S words; the j=S fold step must not index past them
        ja     = (j_q < JMax) ? j_q : '0;
        t_word = t_q[j_q*W +: W];
        a_word = a_q[ja*W +: W];
        p_word = p_q[ja*W +: W];
        b_word = b_q[i_q*W +: W];
        lo     = t_word + a_word * b_word;
        m_now  = lo * pp_q;
        mac_y  = (j_q < JMax) ? a_word : '0;
        mac_v  = (j_q < JMax) ? p_word : '0;
        mac_u  = (j_q == '0) ? m_now : m_q;
        mac_c  = (j_q == '0) ? '0 : c_q;
    end

    fios_mac #(
        .W (W)
    ) u_mac (
        .x_i (t_word),
        .y_i (mac_y),
        .z_i (b_word),
        .u_i (mac_u),
        .v_i (mac_v),
        .c_i (mac_c),
        .s_o (mac_s)
    );

`ifdef FIOS_FINAL_SUB_EN
    logic [N-1:0] d_q;
    logic         bor_q;
    logic [W:0]   dw;
    logic         t_ge_p;

    always_comb begin
        dw     = {1'b0, t_word} - {1'b0, p_word} - {{W{1'b0}}, bor_q};
        t_ge_p = (t_q[N +: W] != '0) || !bor_q;
    end
`endif

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            pp_q    <= '0;
            t_q     <= '0;
            m_q     <= '0;
            c_q     <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
`ifdef FIOS_FINAL_SUB_EN
            d_q     <= '0;
            bor_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        p_q     <= p_i;
                        pp_q    <= p_prime_0_i;
                        t_q     <= '0;
                        c_q     <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
`ifdef FIOS_FINAL_SUB_EN
                        bor_q   <= 1'b0;
`endif
                        state_q <= StMul;
                    end
                end
                StMul: begin
                    // Results shift down one word as they are written back.
                    if (j_q == '0) begin
                        m_q <= m_now;
                        c_q <= mac_s[MW-1:W];
                    end else if (j_q != JMax) begin
                        t_q[(j_q-1)*W +: W] <= mac_s[W-1:0];
                        c_q                 <= mac_s[MW-1:W];
                    end else begin
                        t_q[(S-1)*W +: W] <= mac_s[W-1:0];
                        t_q[N +: W]       <= mac_s[2*W-1:W];
                    end
                    if (j_q == JMax) begin
                        j_q <= '0;
                        if (i_q == IMax) begin
                            i_q <= '0;
`ifdef FIOS_FINAL_SUB_EN
                            state_q <= StSub;
`else
                            state_q <= StDone;
`endif
                        end else begin
                            i_q <= i_q + 1'b1;
                        end
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
`ifdef FIOS_FINAL_SUB_EN
                StSub: begin
                    if (j_q != JMax) begin
                        d_q[j_q*W +: W] <= dw[W-1:0];
                        bor_q           <= dw[W];
                        j_q             <= j_q + 1'b1;
                    end else begin
                        if (t_ge_p) begin
                            t_q <= {{W{1'b0}}, d_q};
                        end
                        j_q     <= '0;
                        bor_q   <= 1'b0;
                        state_q <= StDone;
                    end
                end
`endif
                StDone: begin
                    if (!valid_q) begin
                        res_q   <= t_q[N:0];
                        valid_q <= 1'b1;
                    end else if (ready_i) begin
                        res_q   <= '0;
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign idle_o  = (state_q == StIdle);
    assign valid_o = valid_q;
    assign res_o   = res_q;

endmodule
